// File: rtl/clock_step_controller.sv
// Turns rising edges of the divided clock into single-cycle CPU enables, gated by RUN/HALT/STEP front-panel control.
// Optional feature: define CYCLE_COUNT_EN to implement the issued-cycle counter; otherwise cycles reads as 0.
module clock_step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t state;

    logic s1, s2, s3;
    logic tick;

    logic [1:0]      btn_s1, btn_s2;
    logic [1:0]      btn_lvl, btn_lvl_q, btn_press;
    logic [DB_W-1:0] db_cnt [2];

    logic run_press, step_press;

    // Divided clock is asynchronous data: synchronize, then detect its rising edge.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= slow_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    // Buttons: bit 0 is run, bit 1 is step; each synchronized, debounced and edge-detected on press only.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_lvl   <= '0;
            btn_lvl_q <= '0;
            btn_press <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_s1    <= {step_btn, run_btn};
            btn_s2    <= btn_s1;
            btn_lvl_q <= btn_lvl;
            btn_press <= btn_lvl & ~btn_lvl_q;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] != btn_lvl[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        btn_lvl[i] <= ~btn_lvl[i];
                        db_cnt[i]  <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign run_press  = btn_press[0];
    assign step_press = btn_press[1];

    // Run control; halt_req outranks run_press, which outranks step_press, which outranks tick.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HALT;
            cpu_en  <= 1'b0;
            running <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            case (state)
                HALT: begin
                    if (run_press) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (step_press) begin
                        state <= STEP;
                    end
                end
                RUN: begin
                    if (halt_req || run_press) begin
                        state   <= HALT;
                        running <= 1'b0;
                    end else if (tick) begin
                        cpu_en <= 1'b1;
                    end
                end
                STEP: begin
                    if (tick) begin
                        cpu_en <= 1'b1;
                        state  <= HALT;
                    end
                end
                default: begin
                    state   <= HALT;
                    running <= 1'b0;
                end
            endcase
        end
    end

`ifdef CYCLE_COUNT_EN
    // Counts issued enables; wraps silently.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= '0;
        end else if (cpu_en) begin
            cycles <= cycles + CNT_W'(1);
        end
    end
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_clock_step_controller.sv
// Bench for clock_step_controller: phase table plus hand-written corner sequences, pulses checked against a queue of expected cycles.
module tb_clock_step_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       slow_clk = 1'b0;
    logic       run_btn = 1'b0;
    logic       step_btn = 1'b0;
    logic       halt_req = 1'b0;
    logic       cpu_en;
    logic       running;
    logic [3:0] cycles;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_q [$];
    logic prev_en = 1'b0;

    clock_step_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clkin    (clk),
        .rst_n    (rst_n),
        .slow_clk (slow_clk),
        .run_btn  (run_btn),
        .step_btn (step_btn),
        .halt_req (halt_req),
        .cpu_en   (cpu_en),
        .running  (running),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected counter value: modulo 16 when the counter exists, constant zero otherwise.
    function automatic int ec(input int v);
`ifdef CYCLE_COUNT_EN
        return v % 16;
`else
        return 0 * v;
`endif
    endfunction

    // Every enable pulse must match the oldest expected pulse cycle.
    always @(negedge clk) begin
        if (cpu_en) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got cpu_en=1 at cycle %0d, expected none", cyc);
            end else begin
                chk("pulse_cycle", cyc, exp_q.pop_front());
            end
            if (prev_en) chk("back_to_back_en", 1, 0);
        end
        prev_en = cpu_en;
    end

    // One slow_clk period of 40 clkin cycles; a pulse is due on the third clkin edge after the rise.
    task automatic rise(input bit expect_pulse);
        @(posedge clk); #1;
        slow_clk = 1'b1;
        if (expect_pulse) exp_q.push_back(cyc + 3);
        repeat (20) @(posedge clk);
        #1 slow_clk = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    // Holds a button 10 cycles, then waits out the release; optionally checks running-toggle latency.
    task automatic press(input bit is_run, input bit measure);
        logic r0;
        int   t0;
        int   lat;
        r0  = running;
        lat = -1;
        @(posedge clk); #1;
        if (is_run) run_btn = 1'b1; else step_btn = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (i == 9) begin
                run_btn  = 1'b0;
                step_btn = 1'b0;
            end
            if (lat < 0 && running != r0) lat = cyc - t0;
        end
        if (measure) chk("run_latency_in_7_to_9", int'(lat >= 7 && lat <= 9), 1);
    endtask

    typedef enum int {OP_QUIET, OP_PULSE, OP_RUN, OP_STEP} op_t;
    typedef struct {
        op_t  op;
        int   n;
        logic exp_running;
        int   exp_cycles;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int   n0;

        vecs[0] = '{OP_QUIET, 5, 1'b0, 0};
        vecs[1] = '{OP_RUN,   1, 1'b1, 0};
        vecs[2] = '{OP_PULSE, 5, 1'b1, 5};
        vecs[3] = '{OP_RUN,   1, 1'b0, 5};
        vecs[4] = '{OP_QUIET, 2, 1'b0, 5};
        vecs[5] = '{OP_STEP,  1, 1'b0, 5};
        vecs[6] = '{OP_PULSE, 1, 1'b0, 6};
        vecs[7] = '{OP_QUIET, 2, 1'b0, 6};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cpu_en", int'(cpu_en), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_cycles", int'(cycles), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                case (vecs[v].op)
                    OP_QUIET: rise(1'b0);
                    OP_PULSE: rise(1'b1);
                    OP_RUN:   press(1'b1, 1'b1);
                    default:  press(1'b0, 1'b0);
                endcase
            end
            @(negedge clk);
            chk($sformatf("vec%0d_running", v), int'(running), int'(vecs[v].exp_running));
            chk($sformatf("vec%0d_cycles", v), int'(cycles), ec(vecs[v].exp_cycles));
            chk($sformatf("vec%0d_pending", v), exp_q.size(), 0);
        end

        // Two-cycle glitch on run must not change state.
        @(posedge clk); #1 run_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1 run_btn = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("glitch_running", int'(running), 0);

        // halt_req coinciding with a tick in RUN suppresses that pulse.
        press(1'b1, 1'b1);
        @(posedge clk); #1 slow_clk = 1'b1;
        repeat (2) @(posedge clk);
        #1 halt_req = 1'b1;
        @(posedge clk);
        #1 halt_req = 1'b0;
        chk("halt_tick_running", int'(running), 0);
        chk("halt_tick_cpu_en", int'(cpu_en), 0);
        repeat (18) @(posedge clk);
        #1 slow_clk = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("halt_tick_cycles", int'(cycles), ec(6));
        press(1'b0, 1'b0);
        rise(1'b1);
        rise(1'b0);
        @(negedge clk);
        chk("step_after_halt_cycles", int'(cycles), ec(7));
        chk("step_after_halt_running", int'(running), 0);

        // Reset while halted, then run 17 ticks to wrap the 4-bit counter.
        #2 rst_n = 1'b0;
        #1 chk("rst2_cycles", int'(cycles), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        press(1'b1, 1'b1);
        for (int k = 0; k < 17; k++) rise(1'b1);
        @(negedge clk);
        chk("wrap_cycles", int'(cycles), ec(17));
        chk("wrap_running", int'(running), 1);

        // Asynchronous reset in the middle of an enable pulse.
        @(posedge clk); #1 slow_clk = 1'b1;
        exp_q.push_back(cyc + 3);
        n0 = 0;
        for (int i = 0; i < 10 && n0 == 0; i++) begin
            @(negedge clk);
            if (cpu_en) n0 = 1;
        end
        chk("midpulse_seen", n0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midpulse_rst_cpu_en", int'(cpu_en), 0);
        chk("midpulse_rst_running", int'(running), 0);
        chk("midpulse_rst_cycles", int'(cycles), 0);
        slow_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("final_pending", exp_q.size(), 0);
        chk("final_running", int'(running), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
